// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared FSM state encoding and opcode class constants
// Rev 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    OPND   = 3'd3,
    EMIT   = 3'd4,
    ADV    = 3'd5,
    WAIT   = 3'd6,
    HALT   = 3'd7
  } state_e;

  localparam logic [1:0] CLS_SEQ = 2'b00;
  localparam logic [1:0] CLS_JMP = 2'b01;
  localparam logic [1:0] CLS_HLT = 2'b10;
  localparam logic [1:0] CLS_JCC = 2'b11;

endpackage
`default_nettype wire

// File: rtl/fetch_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_decode : opcode -> class, operand requirement and PC step size
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_decode
  import fetch_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] opcode,
  output logic [1:0]    cls,
  output logic          needs_operand,
  output logic [2:0]    step
);

  always_comb begin
    cls           = opcode[DW-1 -: 2];
    needs_operand = (cls == CLS_JMP) || (cls == CLS_JCC);
    // A zero step would stall the PC forever, so it is promoted to 1.
    step          = (opcode[2:0] == 3'd0) ? 3'd1 : opcode[2:0];
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_ctrl : fetches opcode/operand bytes and steers the PC control pins
// Rev 1.0
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          resume,
  input  logic          cond_in,
  input  logic [AW-1:0] pc_in,
  output logic          pc_enable,
  output logic          pc_hold,
  output logic          pc_load,
  output logic [AW-1:0] pc_load_value,
  output logic [2:0]    pc_step,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [DW-1:0] ins_opcode,
  output logic [DW-1:0] ins_operand,
  output logic          halted,
  output logic          bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] opcode_q, opcode_d, operand_q, operand_d;
  logic          pc_enable_q, pc_enable_d, pc_hold_q, pc_hold_d, pc_load_q, pc_load_d;
  logic [AW-1:0] pc_load_value_q, pc_load_value_d, mem_addr_q, mem_addr_d;
  logic [2:0]    pc_step_q, pc_step_d;
  logic          mem_req_q, mem_req_d, ins_valid_q, ins_valid_d;
  logic          halted_q, halted_d, bus_err_q, bus_err_d;

  logic [1:0]    dec_cls;
  logic          dec_needs_operand;
  logic [2:0]    dec_step;
  logic          timeout;

  fetch_decode #(.DW(DW)) u_decode (
    .opcode        (opcode_q),
    .cls           (dec_cls),
    .needs_operand (dec_needs_operand),
    .step          (dec_step)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = '0;
    opcode_d        = opcode_q;
    operand_d       = operand_q;
    pc_load_value_d = pc_load_value_q;
    pc_step_d       = pc_step_q;
    mem_addr_d      = mem_addr_q;
    bus_err_d       = bus_err_q;
    pc_load_d       = 1'b0;

    // An ack on the last allowed cycle takes priority over the timeout.
    timeout = mem_req_q && !mem_ack && (cnt_q == CW'(TIMEOUT - 1));
    if (mem_req_q && !mem_ack && !timeout) cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: if (start) begin
        state_d   = FETCH;
        bus_err_d = 1'b0;
      end
      FETCH: if (mem_ack) begin
        opcode_d = mem_rdata;
        state_d  = DECODE;
      end else if (timeout) begin
        bus_err_d = 1'b1;
        state_d   = IDLE;
      end
      DECODE: if (dec_needs_operand) begin
        state_d = OPND;
      end else begin
        operand_d = '0;
        state_d   = EMIT;
      end
      OPND: if (mem_ack) begin
        operand_d = mem_rdata;
        state_d   = EMIT;
      end else if (timeout) begin
        bus_err_d = 1'b1;
        state_d   = IDLE;
      end
      EMIT:    if (ins_ready) state_d = ADV;
      ADV:     state_d = (dec_cls == CLS_HLT) ? HALT : WAIT;
      WAIT:    state_d = FETCH;
      HALT:    if (resume) state_d = WAIT;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    pc_enable_d = (state_d != IDLE);
    pc_hold_d   = (state_d != ADV);
    mem_req_d   = (state_d == FETCH) || (state_d == OPND);
    ins_valid_d = (state_d == EMIT);
    halted_d    = (state_d == HALT);

    if (state_d == FETCH && state_q != FETCH) mem_addr_d = pc_in;
    if (state_d == OPND && state_q != OPND)   mem_addr_d = pc_in + AW'(1);

    // cond_in is taken on the edge that enters ADV and held through that cycle.
    if (state_q == EMIT && state_d == ADV) begin
      case (dec_cls)
        CLS_SEQ: pc_step_d = dec_step;
        CLS_JMP: begin
          pc_load_d       = 1'b1;
          pc_load_value_d = AW'(operand_q);
        end
        CLS_JCC: if (cond_in) begin
          pc_load_d       = 1'b1;
          pc_load_value_d = AW'(operand_q);
        end else begin
          pc_step_d = 3'd2;
        end
        default: pc_step_d = 3'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      opcode_q        <= '0;
      operand_q       <= '0;
      pc_enable_q     <= 1'b0;
      pc_hold_q       <= 1'b1;
      pc_load_q       <= 1'b0;
      pc_load_value_q <= '0;
      pc_step_q       <= 3'd1;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      ins_valid_q     <= 1'b0;
      halted_q        <= 1'b0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      opcode_q        <= opcode_d;
      operand_q       <= operand_d;
      pc_enable_q     <= pc_enable_d;
      pc_hold_q       <= pc_hold_d;
      pc_load_q       <= pc_load_d;
      pc_load_value_q <= pc_load_value_d;
      pc_step_q       <= pc_step_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      ins_valid_q     <= ins_valid_d;
      halted_q        <= halted_d;
      bus_err_q       <= bus_err_d;
    end
  end

  assign pc_enable     = pc_enable_q;
  assign pc_hold       = pc_hold_q;
  assign pc_load       = pc_load_q;
  assign pc_load_value = pc_load_value_q;
  assign pc_step       = pc_step_q;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign ins_valid     = ins_valid_q;
  assign ins_opcode    = opcode_q;
  assign ins_operand   = operand_q;
  assign halted        = halted_q;
  assign bus_err       = bus_err_q;

endmodule
`default_nettype wire
